ip_rx_check: RTL and testbench

- Receive-side counterpart of the IPv4 header generator.
- Consumes the 20-byte IPv4 header of an incoming packet one byte at a time.
- Verifies the header fields and the ones-complement header checksum.
- Checks the destination address against the local IP, then reports source IP, protocol and payload length to the UDP/VPN receive path.

---
 rtl/ip_rx_check.sv | 162 ++++++++++++++++
 tb/tb_ip_rx_check.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/ip_rx_check.sv
// IPv4 receive header checker: collects a 20-byte header, verifies fields, checksum and destination.
// Optional: define IP_RX_BCAST_EN to also accept the broadcast destination 255.255.255.255.
module ip_rx_check #(
    parameter logic [31:0] LOCAL_IP_INIT = 32'hC0A80105,
    parameter int          HDR_LEN       = 20
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_byte_valid,
    input  logic [7:0]  i_byte,
    input  logic        i_sof,
    input  logic        i_set_local,
    input  logic [7:0]  i_ip0,
    input  logic [7:0]  i_ip1,
    input  logic [7:0]  i_ip2,
    input  logic [7:0]  i_ip3,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_ok,
    output logic [2:0]  o_err,
    output logic [31:0] o_src_ip,
    output logic [7:0]  o_protocol,
    output logic [15:0] o_payload_len
);

    typedef enum logic [1:0] {
        IDLE,
        HDR,
        CHECK,
        DONE
    } state_t;

    localparam logic [4:0]  LAST_IDX = 5'(HDR_LEN - 1);
    localparam logic [15:0] HDR_LEN_W = 16'(HDR_LEN);

    state_t      state;
    logic [4:0]  cnt;
    logic [15:0] acc;
    logic [7:0]  hi;
    logic [7:0]  ver_ihl;
    logic [15:0] tot_len;
    logic [15:0] frag;
    logic [7:0]  proto;
    logic [31:0] src;
    logic [31:0] dst;
    logic [31:0] local_ip;

    logic        take;
    logic [4:0]  idx;
    logic [16:0] s17;
    logic        dst_ok;
    logic [2:0]  err_code;

    // A valid i_sof always restarts at index 0, whether from IDLE or mid-header.
    always_comb begin
        take = i_byte_valid && ((state == IDLE && i_sof) || state == HDR);
        idx  = i_sof ? 5'd0 : cnt;
        s17  = {1'b0, acc} + {1'b0, hi, i_byte};
    end

`ifdef IP_RX_BCAST_EN
    assign dst_ok = (dst == local_ip) || (dst == 32'hFFFF_FFFF);
`else
    assign dst_ok = (dst == local_ip);
`endif

    // NOTE: every branch assigns err_code after a default, so no latch is inferred.
    always_comb begin
        err_code = 3'd0;
        if (ver_ihl != 8'h45)
            err_code = 3'd1;
        else if (tot_len < HDR_LEN_W)
            err_code = 3'd2;
        else if (frag[13] || frag[12:0] != 13'd0)
            err_code = 3'd3;
        else if (acc != 16'hFFFF)
            err_code = 3'd4;
        else if (!dst_ok)
            err_code = 3'd5;
    end

    assign o_busy = (state != IDLE);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            local_ip <= LOCAL_IP_INIT;
        end else if (i_set_local) begin
            local_ip <= {i_ip0, i_ip1, i_ip2, i_ip3};
        end
    end

    // NOTE: all state is updated with non-blocking assignments so every read sees pre-edge values.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state         <= IDLE;
            cnt           <= 5'd0;
            acc           <= 16'd0;
            hi            <= 8'd0;
            ver_ihl       <= 8'd0;
            tot_len       <= 16'd0;
            frag          <= 16'd0;
            proto         <= 8'd0;
            src           <= 32'd0;
            dst           <= 32'd0;
            o_done        <= 1'b0;
            o_ok          <= 1'b0;
            o_err         <= 3'd0;
            o_src_ip      <= 32'd0;
            o_protocol    <= 8'd0;
            o_payload_len <= 16'd0;
        end else begin
            o_done <= 1'b0;
            case (state)
                IDLE, HDR: begin
                    if (take) begin
                        cnt <= idx + 5'd1;
                        if (!idx[0]) begin
                            hi <= i_byte;
                            if (idx == 5'd0)
                                acc <= 16'd0;
                        end else begin
                            // End-around carry keeps the ones-complement sum in 16 bits.
                            acc <= s17[15:0] + {15'd0, s17[16]};
                        end
                        case (idx)
                            5'd0:    ver_ihl       <= i_byte;
                            5'd2:    tot_len[15:8] <= i_byte;
                            5'd3:    tot_len[7:0]  <= i_byte;
                            5'd6:    frag[15:8]    <= i_byte;
                            5'd7:    frag[7:0]     <= i_byte;
                            5'd9:    proto         <= i_byte;
                            5'd12:   src[31:24]    <= i_byte;
                            5'd13:   src[23:16]    <= i_byte;
                            5'd14:   src[15:8]     <= i_byte;
                            5'd15:   src[7:0]      <= i_byte;
                            5'd16:   dst[31:24]    <= i_byte;
                            5'd17:   dst[23:16]    <= i_byte;
                            5'd18:   dst[15:8]     <= i_byte;
                            5'd19:   dst[7:0]      <= i_byte;
                            default: ;
                        endcase
                        state <= (idx == LAST_IDX) ? CHECK : HDR;
                    end
                end
                CHECK: begin
                    o_done        <= 1'b1;
                    o_ok          <= (err_code == 3'd0);
                    o_err         <= err_code;
                    o_src_ip      <= src;
                    o_protocol    <= proto;
                    o_payload_len <= (err_code == 3'd0) ? (tot_len - HDR_LEN_W) : 16'd0;
                    state         <= DONE;
                end
                DONE: begin
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ip_rx_check.sv
// Directed self-checking bench for ip_rx_check using hand-computed IPv4 headers.
module tb_ip_rx_check;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic        i_byte_valid;
    logic [7:0]  i_byte;
    logic        i_sof;
    logic        i_set_local;
    logic [7:0]  i_ip0, i_ip1, i_ip2, i_ip3;
    logic        o_busy;
    logic        o_done;
    logic        o_ok;
    logic [2:0]  o_err;
    logic [31:0] o_src_ip;
    logic [7:0]  o_protocol;
    logic [15:0] o_payload_len;

    int total = 0;
    int bad   = 0;
    int done_cnt = 0;
    int done_base;

    logic [7:0] hdr [20];
    localparam logic [7:0] BASE [20] = '{
        8'h45, 8'h00, 8'h00, 8'h3C, 8'h1C, 8'h46, 8'h40, 8'h00, 8'h40, 8'h06,
        8'hB1, 8'hE6, 8'hAC, 8'h10, 8'h0A, 8'h63, 8'hAC, 8'h10, 8'h0A, 8'h0C
    };

    ip_rx_check dut (
        .i_clk         (i_clk),
        .i_rst         (i_rst),
        .i_byte_valid  (i_byte_valid),
        .i_byte        (i_byte),
        .i_sof         (i_sof),
        .i_set_local   (i_set_local),
        .i_ip0         (i_ip0),
        .i_ip1         (i_ip1),
        .i_ip2         (i_ip2),
        .i_ip3         (i_ip3),
        .o_busy        (o_busy),
        .o_done        (o_done),
        .o_ok          (o_ok),
        .o_err         (o_err),
        .o_src_ip      (o_src_ip),
        .o_protocol    (o_protocol),
        .o_payload_len (o_payload_len)
    );

    always #5 i_clk = ~i_clk;

    always @(posedge i_clk) begin
        if (o_done)
            done_cnt <= done_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Inputs change on the falling edge so the DUT samples them cleanly on the next rising edge.
    task automatic send_bytes(input int first, input int last, input bit gaps);
        for (int i = first; i <= last; i++) begin
            @(negedge i_clk);
            i_byte_valid = 1'b1;
            i_byte       = hdr[i];
            i_sof        = (i == 0);
            if (gaps && (i % 3 == 2) && i != last) begin
                @(negedge i_clk);
                i_byte_valid = 1'b0;
                i_sof        = 1'b0;
                i_byte       = 8'hEE;
            end
        end
    endtask

    task automatic expect_result(input string tag, input logic ok, input logic [2:0] err,
                                 input logic [31:0] src, input logic [7:0] proto,
                                 input logic [15:0] plen);
        @(negedge i_clk);
        i_byte_valid = 1'b0;
        i_sof        = 1'b0;
        check({tag, ".check_nodone"}, {31'd0, o_done}, 32'd0);
        check({tag, ".check_busy"}, {31'd0, o_busy}, 32'd1);
        @(negedge i_clk);
        check({tag, ".done"}, {31'd0, o_done}, 32'd1);
        check({tag, ".ok"}, {31'd0, o_ok}, {31'd0, ok});
        check({tag, ".err"}, {29'd0, o_err}, {29'd0, err});
        check({tag, ".src"}, o_src_ip, src);
        check({tag, ".proto"}, {24'd0, o_protocol}, {24'd0, proto});
        check({tag, ".plen"}, {16'd0, o_payload_len}, {16'd0, plen});
        @(negedge i_clk);
        check({tag, ".done_drop"}, {31'd0, o_done}, 32'd0);
        check({tag, ".idle"}, {31'd0, o_busy}, 32'd0);
        check({tag, ".hold_err"}, {29'd0, o_err}, {29'd0, err});
    endtask

    initial begin
        i_rst        = 1'b1;
        i_byte_valid = 1'b0;
        i_byte       = 8'h00;
        i_sof        = 1'b0;
        i_set_local  = 1'b0;
        {i_ip0, i_ip1, i_ip2, i_ip3} = 32'h0;
        repeat (2) @(negedge i_clk);
        i_rst = 1'b0;
        @(negedge i_clk);

        check("rst.busy", {31'd0, o_busy}, 32'd0);
        check("rst.done", {31'd0, o_done}, 32'd0);
        check("rst.ok", {31'd0, o_ok}, 32'd0);
        check("rst.err", {29'd0, o_err}, 32'd0);
        check("rst.src", o_src_ip, 32'd0);
        check("rst.plen", {16'd0, o_payload_len}, 32'd0);

        // Non-sof bytes in IDLE are ignored.
        @(negedge i_clk);
        i_byte_valid = 1'b1;
        i_byte       = 8'h45;
        @(negedge i_clk);
        i_byte_valid = 1'b0;
        check("idle_ignore.busy", {31'd0, o_busy}, 32'd0);

        // Local IP still at reset value: destination mismatch.
        hdr = BASE;
        send_bytes(0, 19, 1'b0);
        expect_result("reset_local", 1'b0, 3'd5, 32'hAC100A63, 8'h06, 16'd0);

        @(negedge i_clk);
        i_set_local = 1'b1;
        {i_ip0, i_ip1, i_ip2, i_ip3} = 32'hAC100A0C;
        @(negedge i_clk);
        i_set_local = 1'b0;
        {i_ip0, i_ip1, i_ip2, i_ip3} = 32'h0;

        send_bytes(0, 19, 1'b0);
        expect_result("good", 1'b1, 3'd0, 32'hAC100A63, 8'h06, 16'd40);

        hdr[10] = 8'hB2;
        send_bytes(0, 19, 1'b0);
        expect_result("bad_csum", 1'b0, 3'd4, 32'hAC100A63, 8'h06, 16'd0);

        hdr = BASE;
        hdr[6] = 8'h20;
        hdr[7] = 8'h00;
        send_bytes(0, 19, 1'b0);
        expect_result("mf_set", 1'b0, 3'd3, 32'hAC100A63, 8'h06, 16'd0);

        hdr[0] = 8'h46;
        send_bytes(0, 19, 1'b0);
        expect_result("ver_prio", 1'b0, 3'd1, 32'hAC100A63, 8'h06, 16'd0);

        hdr = BASE;
        hdr[2] = 8'h00;
        hdr[3] = 8'h10;
        send_bytes(0, 19, 1'b0);
        expect_result("short_len", 1'b0, 3'd2, 32'hAC100A63, 8'h06, 16'd0);

        // Broadcast destination with checksum recomputed to 68 03.
        hdr = BASE;
        hdr[10] = 8'h68;
        hdr[11] = 8'h03;
        for (int i = 16; i < 20; i++) hdr[i] = 8'hFF;
        send_bytes(0, 19, 1'b0);
`ifdef IP_RX_BCAST_EN
        expect_result("bcast", 1'b1, 3'd0, 32'hAC100A63, 8'h06, 16'd40);
`else
        expect_result("bcast", 1'b0, 3'd5, 32'hAC100A63, 8'h06, 16'd0);
`endif

        // Abort at byte 10 with a new sof, then a full header with idle gaps.
        hdr = BASE;
        done_base = done_cnt;
        send_bytes(0, 9, 1'b0);
        send_bytes(0, 19, 1'b1);
        expect_result("abort", 1'b1, 3'd0, 32'hAC100A63, 8'h06, 16'd40);
        check("abort.one_done", done_cnt - done_base, 32'd1);

        // Async reset at byte 15: busy drops at once, no done, local IP reverts.
        done_base = done_cnt;
        send_bytes(0, 14, 1'b0);
        @(negedge i_clk);
        i_byte_valid = 1'b0;
        i_rst = 1'b1;
        #1;
        check("rst_mid.busy", {31'd0, o_busy}, 32'd0);
        @(negedge i_clk);
        i_rst = 1'b0;
        repeat (3) @(negedge i_clk);
        check("rst_mid.no_done", done_cnt - done_base, 32'd0);
        check("rst_mid.err_clr", {29'd0, o_err}, 32'd0);
        send_bytes(0, 19, 1'b0);
        expect_result("rst_mid.local", 1'b0, 3'd5, 32'hAC100A63, 8'h06, 16'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
